// File: rtl/rx_unpack_pkg.sv
// Shared types and defaults for the receive-side frame unpacker.
// Parser state encoding, default widths and a clog2 helper.
package rx_unpack_pkg;

  typedef enum logic {
    S_LEN = 1'b0,
    S_PAY = 1'b1
  } state_t;

  localparam int WORD_W_DEF     = 8;
  localparam int LEN_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Small show-ahead FIFO for unpacked words.
// Head is read combinationally; a push on full is absorbed by a same-cycle pop.
module rx_word_fifo
  import rx_unpack_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         push_ok
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // storage write, no reset needed since empty masks the head
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_frame_unpacker.sv
// Turns the Receiver bit stream into length-prefixed word frames.
// Parser FSM and counters here; words leave through rx_word_fifo.
module rx_frame_unpacker
  import rx_unpack_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int SW = (WORD_W > LEN_W) ? WORD_W : LEN_W;
  localparam int BW = clog2(SW) + 1;
  localparam logic [BW-1:0] LEN_END  = BW'(LEN_W - 1);
  localparam logic [BW-1:0] WORD_END = BW'(WORD_W - 1);

  state_t            state;
  state_t            state_nx;
  logic [SW-1:0]     shreg;
  logic [SW-1:0]     shreg_nx;
  logic [BW-1:0]     bcnt;
  logic [LEN_W-1:0]  remain;
  logic [LEN_W-1:0]  len_val;
  logic              len_done;
  logic              word_done;
  logic              last_word;
  logic              push;
  logic              drop;
  logic              done_evt;
  logic [WORD_W:0]   fifo_din;
  logic [WORD_W:0]   fifo_dout;
  logic              empty;
  logic              full;
  logic              push_ok;

  assign shreg_nx  = {shreg[SW-2:0], bit_in};
  assign len_val   = shreg_nx[LEN_W-1:0];
  assign len_done  = bit_valid & (state == S_LEN)
                   & (bcnt == LEN_END);
  assign word_done = bit_valid & (state == S_PAY)
                   & (bcnt == WORD_END);
  assign last_word = (remain == LEN_W'(1));

  // parser state register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= S_LEN;
    else       state <= state_nx;
  end

  // next state: empty frames never leave S_LEN
  always_comb begin
    state_nx = state;
    unique case (state)
      S_LEN: if (len_done && len_val != '0) state_nx = S_PAY;
      S_PAY: if (word_done && last_word)    state_nx = S_LEN;
    endcase
  end

  // outputs of the parser: word push and frame-end event
  always_comb begin
    push     = word_done;
    fifo_din = {last_word, shreg_nx[WORD_W-1:0]};
    done_evt = (len_done && len_val == '0)
             | (word_done && last_word);
  end

  // shift register, bit counter and words-remaining counter
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      bcnt   <= '0;
      remain <= '0;
    end else if (bit_valid) begin
      shreg <= shreg_nx;
      if (len_done || word_done) bcnt <= '0;
      else                       bcnt <= bcnt + BW'(1);
      if (len_done)       remain <= len_val;
      else if (word_done) remain <= remain - LEN_W'(1);
    end
  end

  // a push against a full FIFO not freed by a pop is lost
  assign drop = push & full & ~push_ok;

  // frame-end pulse and sticky overflow flag
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= done_evt;
      overflow   <= overflow | drop;
    end
  end

  rx_word_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .reset   (reset),
    .push    (push),
    .pop     (word_ready),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .empty   (empty),
    .full    (full),
    .push_ok (push_ok)
  );

  assign {word_last, word_out} = fifo_dout;
  assign word_valid = ~empty;
  assign busy       = (state == S_PAY) | word_valid;

endmodule

// File: tb/tb_rx_frame_unpacker.sv
// Directed bench for rx_frame_unpacker.
// Scenario tasks check outputs and the consumed-word log inline.
module tb_rx_frame_unpacker;

  logic       Clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] word_out;
  logic       word_last;
  logic       word_valid;
  logic       word_ready;
  logic       frame_done;
  logic       overflow;
  logic       busy;

  int vec;
  int errs;
  logic [8:0] q[$];

  rx_frame_unpacker dut (
    .Clk        (Clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // log every word the consumer accepts
  always @(negedge Clk) begin
    if (!reset && word_valid && word_ready)
      q.push_back({word_last, word_out});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n,
                           input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in    = v[i];
      bit_valid = 1'b1;
      @(posedge Clk);
      #1;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      if (gap && i > 0) idle(1);
    end
  endtask

  task automatic pop_log(output logic [8:0] w);
    if (q.size() > 0) w = q.pop_front();
    else              w = 9'bx;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    word_ready = 1'b0;
    idle(2);
    vec++;
    if ({word_out, word_last, word_valid, frame_done, overflow, busy}
        !== 13'h0) begin
      errs++;
      $display("FAIL reset_outputs got %h want 0",
        {word_out, word_last, word_valid, frame_done, overflow, busy});
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_frame(input bit gap);
    logic [8:0] w;
    q.delete();
    word_ready = 1'b1;
    send_bits(8'h02, 8, gap);
    send_bits(8'hA5, 8, gap);
    vec++;
    if ({word_valid, word_last, word_out} !== {1'b1, 1'b0, 8'hA5}) begin
      errs++;
      $display("FAIL first_word_head gap=%0d got %b %b %h want 1 0 a5",
        gap, word_valid, word_last, word_out);
    end
    vec++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL busy_in_payload got %b want 1", busy);
    end
    send_bits(8'h3C, 8, gap);
    vec++;
    if (frame_done !== 1'b1) begin
      errs++;
      $display("FAIL frame_done_pulse gap=%0d got %b want 1",
        gap, frame_done);
    end
    idle(1);
    vec++;
    if (frame_done !== 1'b0) begin
      errs++;
      $display("FAIL frame_done_width gap=%0d got %b want 0",
        gap, frame_done);
    end
    idle(3);
    vec++;
    if (q.size() !== 2) begin
      errs++;
      $display("FAIL frame_word_count gap=%0d got %0d want 2",
        gap, q.size());
    end
    pop_log(w);
    vec++;
    if (w !== 9'h0A5) begin
      errs++;
      $display("FAIL frame_word0 gap=%0d got %h want 0a5", gap, w);
    end
    pop_log(w);
    vec++;
    if (w !== 9'h13C) begin
      errs++;
      $display("FAIL frame_word1 gap=%0d got %h want 13c", gap, w);
    end
    vec++;
    if ({overflow, busy} !== 2'b00) begin
      errs++;
      $display("FAIL frame_idle_flags got %b want 00", {overflow, busy});
    end
  endtask

  task automatic test_zero_length;
    logic [8:0] w;
    q.delete();
    word_ready = 1'b1;
    send_bits(8'h00, 8, 0);
    vec++;
    if ({frame_done, word_valid, busy} !== 3'b100) begin
      errs++;
      $display("FAIL zero_len_done got %b want 100",
        {frame_done, word_valid, busy});
    end
    send_bits(8'h01, 8, 0);
    send_bits(8'hFF, 8, 0);
    vec++;
    if (frame_done !== 1'b1) begin
      errs++;
      $display("FAIL zero_len_next_done got %b want 1", frame_done);
    end
    idle(3);
    vec++;
    if (q.size() !== 1) begin
      errs++;
      $display("FAIL zero_len_count got %0d want 1", q.size());
    end
    pop_log(w);
    vec++;
    if (w !== 9'h1FF) begin
      errs++;
      $display("FAIL zero_len_word got %h want 1ff", w);
    end
  endtask

  task automatic test_overflow;
    logic [8:0] w;
    q.delete();
    word_ready = 1'b0;
    send_bits(8'h06, 8, 0);
    for (int k = 1; k <= 4; k++) send_bits(32'(k), 8, 0);
    vec++;
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL ovf_early got %b want 0", overflow);
    end
    send_bits(8'h05, 8, 0);
    vec++;
    if (overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_set got %b want 1", overflow);
    end
    send_bits(8'h06, 8, 0);
    vec++;
    if ({frame_done, overflow} !== 2'b11) begin
      errs++;
      $display("FAIL ovf_done_sticky got %b want 11",
        {frame_done, overflow});
    end
    vec++;
    if ({word_valid, word_last, word_out} !== {2'b10, 8'h01}) begin
      errs++;
      $display("FAIL ovf_head got %b %b %h want 1 0 01",
        word_valid, word_last, word_out);
    end
    word_ready = 1'b1;
    idle(6);
    word_ready = 1'b0;
    vec++;
    if (q.size() !== 4) begin
      errs++;
      $display("FAIL ovf_drain_count got %0d want 4", q.size());
    end
    for (int k = 1; k <= 4; k++) begin
      pop_log(w);
      vec++;
      if (w !== 9'(k)) begin
        errs++;
        $display("FAIL ovf_drain_word%0d got %h want %h", k, w, 9'(k));
      end
    end
    vec++;
    if ({overflow, word_valid} !== 2'b10) begin
      errs++;
      $display("FAIL ovf_after_drain got %b want 10",
        {overflow, word_valid});
    end
  endtask

  task automatic test_push_pop_full;
    logic [8:0] w;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    q.delete();
    word_ready = 1'b0;
    send_bits(8'h05, 8, 0);
    for (int k = 1; k <= 4; k++) send_bits(32'(k), 8, 0);
    send_bits(8'h02, 7, 0);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    word_ready = 1'b1;
    idle(1);
    bit_valid = 1'b0;
    bit_in = 1'b0;
    word_ready = 1'b0;
    vec++;
    if ({overflow, frame_done} !== 2'b01) begin
      errs++;
      $display("FAIL pp_flags got %b want 01", {overflow, frame_done});
    end
    vec++;
    if (word_out !== 8'h02) begin
      errs++;
      $display("FAIL pp_head got %h want 02", word_out);
    end
    word_ready = 1'b1;
    idle(6);
    vec++;
    if (q.size() !== 5) begin
      errs++;
      $display("FAIL pp_count got %0d want 5", q.size());
    end
    for (int k = 1; k <= 5; k++) begin
      pop_log(w);
      vec++;
      if (w !== {k == 5, 8'(k)}) begin
        errs++;
        $display("FAIL pp_word%0d got %h want %h", k, w,
          {k == 5, 8'(k)});
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [8:0] w;
    q.delete();
    word_ready = 1'b0;
    send_bits(8'h01, 8, 0);
    send_bits(8'h33, 8, 0);
    send_bits(8'h02, 8, 0);
    send_bits(4'hA, 4, 0);
    vec++;
    if ({word_valid, busy} !== 2'b11) begin
      errs++;
      $display("FAIL mid_pre got %b want 11", {word_valid, busy});
    end
    reset = 1'b1;
    #2;
    vec++;
    if ({word_out, word_last, word_valid, frame_done, overflow, busy}
        !== 13'h0) begin
      errs++;
      $display("FAIL mid_async_reset got %h want 0",
        {word_out, word_last, word_valid, frame_done, overflow, busy});
    end
    @(posedge Clk);
    #1;
    reset = 1'b0;
    q.delete();
    word_ready = 1'b1;
    send_bits(8'h01, 8, 0);
    send_bits(8'h5A, 8, 0);
    vec++;
    if (frame_done !== 1'b1) begin
      errs++;
      $display("FAIL mid_next_done got %b want 1", frame_done);
    end
    idle(3);
    vec++;
    if (q.size() !== 1) begin
      errs++;
      $display("FAIL mid_next_count got %0d want 1", q.size());
    end
    pop_log(w);
    vec++;
    if (w !== 9'h15A) begin
      errs++;
      $display("FAIL mid_next_word got %h want 15a", w);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_zero_length();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/rx_frame_unpacker.md
Name: rx_frame_unpacker

Overview:
- Sits directly downstream of the serial Receiver and consumes its data_out / data_out_valid bit stream.
- Parses length-prefixed frames:
  - LEN_W-bit length field (word count), MSB first.
  - Followed by that many WORD_W-bit payload words, MSB first.
- Packs payload words and delivers them through a small show-ahead FIFO with valid/ready handshake to the MLP input loader.

Parameters:
WORD_W, 8, payload word width in bits
LEN_W, 8, length field width in bits; frame carries 0..2^LEN_W-1 words
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
Clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
bit_in  in  1  serial bit from Receiver data_out
bit_valid  in  1  qualifies bit_in (Receiver data_out_valid); one bit per cycle when high
word_out  out  WORD_W  FIFO head word
word_last  out  1  head word is last word of its frame
word_valid  out  1  FIFO non-empty
word_ready  in  1  consumer accepts head when word_valid & word_ready
frame_done  out  1  one-cycle pulse at frame end
overflow  out  1  sticky: a completed word was dropped on full FIFO
busy  out  1  high while in S_PAY or FIFO non-empty

Behaviour:
- Reset (async assert, removal sync to Clk): state=S_LEN, shift reg=0, bit count=0, word count=0, FIFO empty. Outputs: word_out=0, word_last=0, word_valid=0, frame_done=0, overflow=0, busy=0.
- Reset mid-frame discards the partial frame and all FIFO contents. The next bit after reset is treated as a length MSB.
- bit_valid=0: all parse state holds. No timeout.
- Shift register: each accepted bit shifts in at LSB (shreg <= {shreg, bit_in}). The first received bit therefore ends up as the MSB.
- State S_LEN:
  - Collect LEN_W bits.
  - On the LEN_W-th valid bit: latch remaining = length, clear bit count.
  - length != 0 -> S_PAY.
  - length == 0 -> stay S_LEN; frame_done pulses the next cycle; nothing pushed.
- State S_PAY:
  - Collect WORD_W bits.
  - On the WORD_W-th valid bit: push {last=(remaining==1), word} and decrement remaining.
  - remaining reaches 0 -> S_LEN, and frame_done pulses the next cycle.
- Latency: the word is written at the edge that samples its final bit. word_valid rises the following cycle if the FIFO was empty.
- FIFO push/pop rules:
  - Push is accepted if not full, or if a pop occurs in the same cycle (simultaneous push+pop on full is legal; count unchanged).
  - Pop on empty is ignored.
- Full-FIFO drop:
  - A push that cannot be accepted drops the word and sets overflow (sticky until reset).
  - Frame tracking continues regardless, so remaining still decrements and frame_done still pulses.
- Show-ahead: word_out/word_last reflect the head combinationally from FIFO storage. Both are 0 when empty.
- Pointers: wrap modulo FIFO_DEPTH, with count register of width clog2(FIFO_DEPTH)+1.
- busy = (state==S_PAY) | word_valid.

Decomposition:
- Package rx_unpack_pkg:
  - State enum S_LEN=1'b0, S_PAY=1'b1.
  - Default WORD_W/LEN_W/FIFO_DEPTH constants.
  - Function clog2.
- Sub-module rx_word_fifo:
  - Parameterized width (WORD_W+1) and depth.
  - Ports: push, pop, din, dout, empty, full, push_ok.
  - Instantiated once.
- The top module holds the parser FSM and counters.

Test Plan:
- Basic frame: bits 00000010, 10100101, 00111100 with bit_valid=1 contiguous, word_ready=1 -> word_out 0xA5 (last=0), then 0x3C (last=1). frame_done pulses one cycle after the 24th bit. overflow=0.
- Gapped input: same frame with bit_valid low every other cycle -> identical words and order. frame_done timing tracks the last valid bit + 1 cycle.
- Zero length: 00000000 followed by frame {length 1, word 0xFF} -> first frame_done with no word pushed, then single word 0xFF with last=1.
- Backpressure/overflow: length 6, words 0x01..0x06, word_ready=0 -> FIFO holds 0x01..0x04. overflow sets on 0x05 and stays set. frame_done still pulses. Raising word_ready drains 0x01..0x04, last=0 on all.
- Simultaneous push/pop on full: FIFO full, word_ready=1 held during 5th word completion -> 5th word accepted, count stays 4, overflow=0.
- Reset mid-frame: assert reset after 12 bits of a length-2 frame -> all outputs 0 immediately (async). Next frame {1, 0x5A} yields 0x5A last=1 correctly.
